// File: rtl/mul_div_unit.sv
// Iterative MIPS multiply/divide unit owning the HI/LO pair.
// One result bit per clock: shift-add multiply (LSB first), restoring divide (MSB first).
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for start; MTHI/MTLO writes serviced here
//   CALC  | WIDTH iterations, counter runs 0..WIDTH-1
//   FIX   | sign correction (or divide-by-zero result), HI/LO write, done
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             Reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             HiWre,
  input  logic             LoWre,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0]   cnt;
  logic               is_div;
  logic               res_neg;
  logic               rem_neg;
  logic [WIDTH-1:0]   operand;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH:0]     rem;
  logic [WIDTH-1:0]   quo;

  logic               a_neg, b_neg, div0_in;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] prod_nxt;
  logic [WIDTH+1:0]   trial;
  logic               trial_ge;
  logic [WIDTH:0]     rem_nxt;
  logic [WIDTH-1:0]   quo_nxt;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  // Operand conditioning at accept: op[0] selects signed, op[1] selects divide
  always_comb begin
    a_neg   = op[0] & a[WIDTH-1];
    b_neg   = op[0] & b[WIDTH-1];
    a_mag   = a_neg ? -a : a;
    b_mag   = b_neg ? -b : b;
    div0_in = op[1] & (b == '0);
  end

  // Multiply step: conditional add of the multiplicand into the upper half, then shift right
  always_comb begin
    mul_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, (prod[0] ? operand : {WIDTH{1'b0}})};
    prod_nxt = {mul_sum, prod[WIDTH-1:1]};
  end

  // Divide step: rem < divisor always holds, so the shifted trial fits WIDTH+1 bits
  always_comb begin
    trial    = {rem, quo[WIDTH-1]};
    trial_ge = trial >= {2'b00, operand};
    rem_nxt  = trial_ge ? WIDTH'(0) + (trial[WIDTH:0] - {1'b0, operand}) : trial[WIDTH:0];
    quo_nxt  = {quo[WIDTH-2:0], trial_ge};
  end

  always_comb begin
    prod_fix = res_neg ? -prod : prod;
    quo_fix  = res_neg ? -quo : quo;
    rem_fix  = rem_neg ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
  end

  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = div0_in ? S_FIX : S_CALC;
      S_CALC:  if (cnt == CNT_LAST) state_nxt = S_FIX;
      S_FIX:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);

  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      cnt      <= '0;
      is_div   <= 1'b0;
      res_neg  <= 1'b0;
      rem_neg  <= 1'b0;
      operand  <= '0;
      prod     <= '0;
      rem      <= '0;
      quo      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (HiWre) hi <= a;
          if (LoWre) lo <= a;
          if (start) begin
            is_div   <= op[1];
            res_neg  <= a_neg ^ b_neg;
            rem_neg  <= a_neg;
            cnt      <= '0;
            div_zero <= div0_in;
            rem      <= '0;
            prod     <= {{WIDTH{1'b0}}, b_mag};
            // on divide-by-zero quo carries the raw dividend through to HI
            quo      <= div0_in ? a : a_mag;
            operand  <= op[1] ? b_mag : a_mag;
          end
        end
        S_CALC: begin
          cnt <= cnt + CNT_W'(1);
          if (is_div) begin
            rem <= rem_nxt;
            quo <= quo_nxt;
          end else begin
            prod <= prod_nxt;
          end
        end
        S_FIX: begin
          done <= 1'b1;
          if (div_zero) begin
            hi <= quo;
            lo <= '1;
          end else if (is_div) begin
            hi <= rem_fix;
            lo <= quo_fix;
          end else begin
            {hi, lo} <= prod_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

- Multi-cycle integer multiply/divide unit owning the HI/LO register pair of the MIPS datapath.
- Sits directly downstream of the register file: operands `a` and `b` are driven by the register file's two read ports (rs and rt values).
- Executes MULT/MULTU/DIV/DIVU iteratively (one bit per cycle) and exposes `busy`/`done` so the control unit can stall the pipeline.
- Also services MTHI/MTLO writes.

## Interface

Parameters:
- `WIDTH`, default 32: operand width. HI and LO are each WIDTH bits.

Ports:
- `clock` in 1: single clock; all state updates on its rising edge.
- `Reset` in 1: asynchronous, active-low reset.
- `start` in 1: request an operation; sampled only in IDLE.
- `op` in 2: operation select. 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- `a` in WIDTH: multiplicand / dividend (rs value).
- `b` in WIDTH: multiplier / divisor (rt value).
- `HiWre` in 1: MTHI; HI <= `a`.
- `LoWre` in 1: MTLO; LO <= `a`.
- `hi` out WIDTH: HI register.
- `lo` out WIDTH: LO register.
- `busy` out 1: high whenever state != IDLE.
- `done` out 1: one-cycle pulse when HI/LO receive a new result.
- `div_zero` out 1: registered flag, set by a divide whose divisor was 0; cleared by the next accepted start.

## Operation

States:
- IDLE: waiting for a request.
- CALC: 32 iterations; a 5-bit counter counts 0..31.
- FIX: sign correction, HI/LO write.

Accepting a request (edge E0, IDLE and `start`=1):
- Latch `op`.
- Latch operand magnitudes. For signed ops negate negative operands; record result sign and remainder sign (remainder sign = dividend sign).
- Clear the counter and `div_zero`.
- Go to CALC, except divide with `b`==0, which goes straight to FIX with `div_zero` set.

Multiply (CALC):
- Shift-add on a 2*WIDTH-bit accumulator, one multiplier bit per edge, LSB first.

Divide (CALC):
- Restoring division, one quotient bit per edge, MSB first.
- Remainder register is WIDTH+1 bits so the trial subtraction never overflows.

CALC exit:
- After the iteration with count=31, go to FIX.

FIX (one edge):
- Multiply: {HI,LO} <= product, negated as 64-bit two's complement if the result sign is negative.
- Divide: LO <= quotient, negated if the operand signs differ (truncate toward zero). HI <= remainder, negated if the dividend was negative.
- Divide by zero: HI <= `a` as latched at E0; LO <= all ones.
- In all cases assert `done` and return to IDLE.

Overflow:
- DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0. No trap.

Request rules:
- `start` while `busy` is ignored, and operands are not re-sampled.
- `start` in the cycle `done` is high is accepted (state is IDLE).

MTHI/MTLO:
- `HiWre`/`LoWre` act only in IDLE; they are ignored while busy.
- If `start` and `HiWre`/`LoWre` are both high in IDLE, the write to HI/LO happens and the operation also starts. The operation's result later overwrites HI/LO.

## Timing

- Reset low, asynchronously and at any time including mid-operation: state IDLE, `hi`=0, `lo`=0, `busy`=0, `done`=0, `div_zero`=0, counter 0. An in-flight operation is discarded.
- Normal op: start sampled at E0. `busy`=1 from after E0 until after E33. HI/LO updated and `done`=1 after E33. `done` is low again after E34 unless a new result lands.
- Result latency is 33 edges from E0.
- Divide by zero: result and `done` after E1, so latency is 1 edge.
- `hi`/`lo` hold their previous values throughout CALC; no intermediate values are visible.
- MTHI/MTLO take effect on the same edge (E+1 latency). They do not pulse `done`.

## Test plan

- MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> after 33 edges hi=0xFFFFFFFE lo=0x00000001, done pulses exactly one cycle, busy low in the done cycle.
- MULT a=0xFFFFFFFD (-3) b=7 -> hi=0xFFFFFFFF lo=0xFFFFFFEB. Then DIV a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD hi=0xFFFFFFFF.
- DIVU a=100 b=7 -> lo=0x0000000E hi=0x00000002. DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000 hi=0, div_zero=0.
- DIVU a=0x1234 b=0 -> done after 1 edge, hi=0x1234 lo=0xFFFFFFFF div_zero=1. Next MULTU 2*3 clears div_zero and gives lo=6.
- During a MULTU, pulse start with op=DIVU and change a/b, and pulse HiWre -> all ignored; original product delivered at E33. Back-to-back start on the done cycle is accepted.
- Drop Reset at edge E10 of a MULT -> hi/lo/busy/done immediately 0. After release, a MTLO with a=0x55 gives lo=0x55 on the next edge with no done pulse.
